// File: rtl/sc_regbank_scroll.sv
// Row bank for the playfield renderer: clear, addressed load, timed scroll, registered readback.
// Define REGBANK_ROTATE_EN to make a scroll recirculate the bottom row into row 0.
module sc_regbank_scroll #(
    parameter int unsigned REGBANK_DATAWIDTH   = 8,
    parameter int unsigned REGBANK_DEPTH       = 8,
    parameter int unsigned REGBANK_ADDRWIDTH   = 3,
    parameter int unsigned REGBANK_PERIODWIDTH = 8
) (
    input  logic                           SC_REGBANK_CLOCK_50,
    input  logic                           SC_REGBANK_RESET_InHigh,
    input  logic                           SC_REGBANK_clear_InLow,
    input  logic                           SC_REGBANK_load_InLow,
    input  logic [REGBANK_ADDRWIDTH-1:0]   SC_REGBANK_wraddr_InBUS,
    input  logic [REGBANK_DATAWIDTH-1:0]   SC_REGBANK_data_InBUS,
    input  logic                           SC_REGBANK_scrollen_InLow,
    input  logic [REGBANK_PERIODWIDTH-1:0] SC_REGBANK_period_InBUS,
    input  logic [REGBANK_DATAWIDTH-1:0]   SC_REGBANK_newrow_InBUS,
    input  logic [REGBANK_ADDRWIDTH-1:0]   SC_REGBANK_rdaddr_InBUS,
    output logic [REGBANK_DATAWIDTH-1:0]   SC_REGBANK_data_OutBUS,
    output logic [REGBANK_DATAWIDTH-1:0]   SC_REGBANK_bottom_OutBUS,
    output logic                           SC_REGBANK_scrolltick_Out
);

    localparam int unsigned DW = REGBANK_DATAWIDTH;
    localparam int unsigned PW = REGBANK_PERIODWIDTH;

    logic [DW-1:0] rows_q [REGBANK_DEPTH];
    logic [DW-1:0] rows_d [REGBANK_DEPTH];
    logic [PW-1:0] cnt_q, cnt_d;
    logic          tick_q, tick_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          scroll;
    logic          wr_in_range;
    logic          rd_in_range;

    assign wr_in_range = 32'(SC_REGBANK_wraddr_InBUS) < REGBANK_DEPTH;
    assign rd_in_range = 32'(SC_REGBANK_rdaddr_InBUS) < REGBANK_DEPTH;

    // Equality compare only: if period drops below cnt, cnt wraps through max before scrolling.
    assign scroll = !SC_REGBANK_scrollen_InLow && (cnt_q == SC_REGBANK_period_InBUS);

    always_comb begin
        rows_d  = rows_q;
        cnt_d   = cnt_q;
        tick_d  = 1'b0;
        rdata_d = rd_in_range ? rows_q[SC_REGBANK_rdaddr_InBUS] : '0;

        if (!SC_REGBANK_clear_InLow) begin
            for (int unsigned i = 0; i < REGBANK_DEPTH; i++) begin
                rows_d[i] = '0;
            end
            cnt_d = '0;
        end else begin
            if (SC_REGBANK_scrollen_InLow) begin
                cnt_d = '0;
            end else if (scroll) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + PW'(1);
            end

            if (scroll) begin
                for (int unsigned i = 1; i < REGBANK_DEPTH; i++) begin
                    rows_d[i] = rows_q[i-1];
                end
`ifdef REGBANK_ROTATE_EN
                rows_d[0] = rows_q[REGBANK_DEPTH-1];
`else
                rows_d[0] = SC_REGBANK_newrow_InBUS;
`endif
                tick_d = 1'b1;
            end

            // Load lands on top of the shifted image so it wins for its own row.
            if (!SC_REGBANK_load_InLow && wr_in_range) begin
                rows_d[SC_REGBANK_wraddr_InBUS] = SC_REGBANK_data_InBUS;
            end
        end
    end

    always_ff @(posedge SC_REGBANK_CLOCK_50) begin
        if (SC_REGBANK_RESET_InHigh) begin
            for (int unsigned i = 0; i < REGBANK_DEPTH; i++) begin
                rows_q[i] <= '0;
            end
            cnt_q   <= '0;
            tick_q  <= 1'b0;
            rdata_q <= '0;
        end else begin
            rows_q  <= rows_d;
            cnt_q   <= cnt_d;
            tick_q  <= tick_d;
            rdata_q <= rdata_d;
        end
    end

    assign SC_REGBANK_data_OutBUS    = rdata_q;
    assign SC_REGBANK_bottom_OutBUS  = rows_q[REGBANK_DEPTH-1];
    assign SC_REGBANK_scrolltick_Out = tick_q;

endmodule
